// File: rtl/i2c_bit_tx_if.sv
// rtl/i2c_bit_tx_if.sv - command/response and open-drain line bundle for the I2C bit driver
interface i2c_bit_tx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic       cmd_wdata;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe;
    logic       sda_oe;
    logic       rsp_valid;
    logic       rsp_rdata;
    logic       arb_lost;
    logic       cmd_err;
    logic       busy;

    // Byte controller and pad side: issues commands, returns filtered line levels
    modport master (
        output cmd_valid, cmd, cmd_wdata, scl_i, sda_i,
        input  cmd_ready, scl_oe, sda_oe, rsp_valid, rsp_rdata, arb_lost, cmd_err, busy
    );

    // Bit driver side
    modport slave (
        input  cmd_valid, cmd, cmd_wdata, scl_i, sda_i,
        output cmd_ready, scl_oe, sda_oe, rsp_valid, rsp_rdata, arb_lost, cmd_err, busy
    );
endinterface

// File: rtl/i2c_bit_tx.sv
// rtl/i2c_bit_tx.sv - I2C bit-level driver: START/STOP/WRITE/READ to open-drain enables
module i2c_bit_tx #(
    parameter int T_LOW  = 5,
    parameter int T_HIGH = 5,
    parameter int T_SU   = 3,
    parameter int T_HD   = 3,
    parameter int CW     = 8
) (
    input  logic         clk,
    input  logic         rst,
    i2c_bit_tx_if.slave  bus
);
    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam logic [CW-1:0] N_LOW  = CW'(T_LOW);
    localparam logic [CW-1:0] N_HIGH = CW'(T_HIGH);
    localparam logic [CW-1:0] N_SU   = CW'(T_SU);
    localparam logic [CW-1:0] N_HD   = CW'(T_HD);
    localparam logic [CW-1:0] ONE    = CW'(1);

    // S_LOW/S_WAIT/S_SU form the repeated-START approach before S_SDA
    typedef enum logic [3:0] {
        IDLE, HOLD, S_LOW, S_WAIT, S_SU, S_SDA,
        BIT_LOW, BIT_WAIT, BIT_HIGH,
        P_LOW, P_WAIT, P_SU, P_FREE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic          scl_q, scl_n;
    logic          sda_q, sda_n;
    logic          rsp_valid_q, rsp_valid_n;
    logic          rsp_rdata_q, rsp_rdata_n;
    logic          arb_q, arb_n;
    logic          err_q, err_n;
    logic          bit_rd, bit_rd_n;
    logic          ready;
    logic          accept;

    assign ready         = (state == IDLE) || (state == HOLD);
    assign accept        = bus.cmd_valid && ready;
    assign bus.cmd_ready = ready;
    assign bus.scl_oe    = scl_q;
    assign bus.sda_oe    = sda_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.arb_lost  = arb_q;
    assign bus.cmd_err   = err_q;
    assign bus.busy      = (state != IDLE);

    // Next state, phase counter and next values of every registered output
    always_comb begin
        state_n     = state;
        count_n     = count;
        scl_n       = scl_q;
        sda_n       = sda_q;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata_q;
        arb_n       = 1'b0;
        err_n       = 1'b0;
        bit_rd_n    = bit_rd;
        case (state)
            IDLE: begin
                if (accept) begin
                    count_n = ONE;
                    if (bus.cmd == CMD_START) begin
                        sda_n   = 1'b1;
                        state_n = S_SDA;
                    end else if (bus.cmd != CMD_STOP) begin
                        err_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    count_n = ONE;
                    case (bus.cmd)
                        CMD_START: begin sda_n = 1'b0; state_n = S_LOW; end
                        CMD_STOP:  begin sda_n = 1'b1; state_n = P_LOW; end
                        CMD_WRITE: begin sda_n = ~bus.cmd_wdata; bit_rd_n = 1'b0; state_n = BIT_LOW; end
                        default:   begin sda_n = 1'b0; bit_rd_n = 1'b1; state_n = BIT_LOW; end
                    endcase
                end
            end
            S_LOW, BIT_LOW, P_LOW: begin
                if (count == N_LOW) begin
                    count_n = ONE;
                    scl_n   = 1'b0;
                    state_n = (state == S_LOW) ? S_WAIT : (state == BIT_LOW) ? BIT_WAIT : P_WAIT;
                end else begin
                    count_n = count + ONE;
                end
            end
            // Clock stretching: counter frozen until SCL is really high
            S_WAIT, BIT_WAIT, P_WAIT: begin
                if (bus.scl_i) begin
                    count_n = ONE;
                    state_n = (state == S_WAIT) ? S_SU : (state == BIT_WAIT) ? BIT_HIGH : P_SU;
                end
            end
            S_SU: begin
                if (count == N_SU) begin
                    count_n = ONE;
                    sda_n   = 1'b1;
                    state_n = S_SDA;
                end else begin
                    count_n = count + ONE;
                end
            end
            S_SDA: begin
                if (count == N_HD) begin
                    count_n = ONE;
                    scl_n   = 1'b1;
                    state_n = HOLD;
                end else begin
                    count_n = count + ONE;
                end
            end
            BIT_HIGH: begin
                if (!bit_rd && !sda_q && !bus.sda_i) begin
                    count_n = ONE;
                    arb_n   = 1'b1;
                    scl_n   = 1'b0;
                    sda_n   = 1'b0;
                    state_n = IDLE;
                end else if (count == N_HIGH) begin
                    count_n     = ONE;
                    rsp_rdata_n = bus.sda_i;
                    rsp_valid_n = 1'b1;
                    scl_n       = 1'b1;
                    state_n     = HOLD;
                end else begin
                    count_n = count + ONE;
                end
            end
            P_SU: begin
                if (count == N_SU) begin
                    count_n = ONE;
                    sda_n   = 1'b0;
                    state_n = P_FREE;
                end else begin
                    count_n = count + ONE;
                end
            end
            P_FREE: begin
                if (count == N_HD) begin
                    count_n = ONE;
                    state_n = IDLE;
                end else begin
                    count_n = count + ONE;
                end
            end
            default: begin
                count_n = ONE;
                scl_n   = 1'b0;
                sda_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset releases both lines immediately
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= ONE;
            scl_q       <= 1'b0;
            sda_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 1'b0;
            arb_q       <= 1'b0;
            err_q       <= 1'b0;
            bit_rd      <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            scl_q       <= scl_n;
            sda_q       <= sda_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            arb_q       <= arb_n;
            err_q       <= err_n;
            bit_rd      <= bit_rd_n;
        end
    end
endmodule

// File: tb/tb_i2c_bit_tx.sv
// tb/tb_i2c_bit_tx.sv - self-checking bench for i2c_bit_tx with response scoreboard
module tb_i2c_bit_tx;
    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_READ  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stretch = 1'b0;
    logic sda_pull = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   rsp_seen = 0;
    int   n;
    logic exp_q[$];

    i2c_bit_tx_if bus();

    i2c_bit_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Wired-AND bus: released lines read high unless the DUT or another agent pulls low
    assign bus.scl_i = ~(bus.scl_oe | stretch);
    assign bus.sda_i = ~(bus.sda_oe | sda_pull);

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until the selected output equals val; an expired bound is a failure
    task automatic wait_sig(input int which, input logic val, output int cnt);
        logic s;
        cnt = 0;
        do begin
            tick();
            cnt++;
            case (which)
                0: s = bus.scl_oe;
                1: s = bus.sda_oe;
                2: s = bus.busy;
                3: s = bus.cmd_ready;
                default: s = bus.arb_lost;
            endcase
        end while (s !== val && cnt < 200);
        if (s !== val) check($sformatf("timeout_sig%0d", which), 0, 1);
    endtask

    task automatic send(input logic [1:0] c, input logic w);
        int k = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd = c;
        bus.cmd_wdata = w;
        while (bus.cmd_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Scoreboard: every response popped against the value queued when the bit was issued
    always @(negedge clk) begin
        if (rst && bus.rsp_valid === 1'b1) begin
            rsp_seen++;
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_rdata", int'(bus.rsp_rdata), int'(exp_q.pop_front()));
        end
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd = 2'b00;
        bus.cmd_wdata = 1'b0;
        tick();
        tick();
        check("rst_scl_oe", int'(bus.scl_oe), 0);
        check("rst_sda_oe", int'(bus.sda_oe), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_rsp", int'(bus.rsp_valid) + int'(bus.rsp_rdata) + int'(bus.arb_lost) + int'(bus.cmd_err), 0);
        @(negedge clk);
        rst = 1'b1;
        check("idle_ready", int'(bus.cmd_ready), 1);

        // 1: START from IDLE
        send(C_START, 1'b0);
        check("start_sda", int'(bus.sda_oe), 1);
        check("start_scl0", int'(bus.scl_oe), 0);
        wait_sig(0, 1'b1, n);
        check("start_hd", n, 3);
        check("hold_ready", int'(bus.cmd_ready), 1);

        // 2: WRITE 0
        exp_q.push_back(1'b0);
        send(C_WRITE, 1'b0);
        check("w0_sda", int'(bus.sda_oe), 1);
        wait_sig(0, 1'b0, n);
        check("w0_low", n, 5);
        // one cycle for scl_i to be seen high, then T_HIGH counted cycles
        wait_sig(0, 1'b1, n);
        check("w0_high", n, 6);
        check("w0_rsp", int'(bus.rsp_valid), 1);
        tick();
        check("w0_sda_keep", int'(bus.sda_oe), 1);

        // 3: READ with clock stretch
        exp_q.push_back(1'b1);
        stretch = 1'b1;
        send(C_READ, 1'b0);
        check("rd_sda", int'(bus.sda_oe), 0);
        wait_sig(0, 1'b0, n);
        check("rd_low", n, 5);
        repeat (20) tick();
        check("rd_stretch_scl", int'(bus.scl_oe), 0);
        check("rd_stretch_rsp", rsp_seen, 1);
        stretch = 1'b0;
        wait_sig(0, 1'b1, n);
        check("rd_high", n, 6);
        tick();
        check("rd_rsp_count", rsp_seen, 2);

        // 4: WRITE 1 loses arbitration
        send(C_WRITE, 1'b1);
        wait_sig(0, 1'b0, n);
        sda_pull = 1'b1;
        wait_sig(4, 1'b1, n);
        check("arb_lat", n, 2);
        check("arb_scl", int'(bus.scl_oe), 0);
        check("arb_sda", int'(bus.sda_oe), 0);
        check("arb_busy", int'(bus.busy), 0);
        sda_pull = 1'b0;
        tick();
        check("arb_pulse", int'(bus.arb_lost), 0);
        check("arb_no_rsp", rsp_seen, 2);

        // 5: START, WRITE 1, repeated START, STOP
        send(C_START, 1'b0);
        wait_sig(0, 1'b1, n);
        exp_q.push_back(1'b1);
        send(C_WRITE, 1'b1);
        wait_sig(3, 1'b1, n);
        send(C_START, 1'b0);
        check("rs_sda_rel", int'(bus.sda_oe), 0);
        check("rs_scl", int'(bus.scl_oe), 1);
        wait_sig(0, 1'b0, n);
        check("rs_low", n, 5);
        wait_sig(1, 1'b1, n);
        check("rs_su", n, 4);
        check("rs_scl_high", int'(bus.scl_oe), 0);
        wait_sig(0, 1'b1, n);
        check("rs_hd", n, 3);
        send(C_STOP, 1'b0);
        check("p_sda", int'(bus.sda_oe), 1);
        wait_sig(0, 1'b0, n);
        check("p_low", n, 5);
        wait_sig(1, 1'b0, n);
        check("p_su", n, 4);
        check("p_scl_high", int'(bus.scl_oe), 0);
        check("p_busy", int'(bus.busy), 1);
        wait_sig(2, 1'b0, n);
        check("p_free", n, 3);

        // 6: READ in IDLE, STOP in IDLE, reset during BIT_HIGH
        send(C_READ, 1'b0);
        check("err_pulse", int'(bus.cmd_err), 1);
        check("err_busy", int'(bus.busy), 0);
        check("err_lines", int'(bus.scl_oe) + int'(bus.sda_oe), 0);
        tick();
        check("err_once", int'(bus.cmd_err), 0);
        send(C_STOP, 1'b0);
        check("stop_idle_busy", int'(bus.busy), 0);
        check("stop_idle_lines", int'(bus.scl_oe) + int'(bus.sda_oe), 0);
        send(C_START, 1'b0);
        wait_sig(0, 1'b1, n);
        send(C_WRITE, 1'b0);
        wait_sig(0, 1'b0, n);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("mid_rst_scl", int'(bus.scl_oe), 0);
        check("mid_rst_sda", int'(bus.sda_oe), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) tick();
        check("post_rst_rsp", rsp_seen, 3);
        check("post_rst_ready", int'(bus.cmd_ready), 1);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
